// File: rtl/fifo_width_down_if.sv
// Bus bundle for fifo_width_down: upstream FWFT FIFO read side plus the
// downstream valid/ready slice stream.
interface fifo_width_down_if #(
    parameter int unsigned IWIDTH = 32,
    parameter int unsigned OWIDTH = 8
);
    logic [IWIDTH-1:0] fifo_dout;
    logic              fifo_empty;
    logic              fifo_read;
    logic [OWIDTH-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (
        input  fifo_dout,
        input  fifo_empty,
        input  m_ready,
        output fifo_read,
        output m_data,
        output m_valid,
        output m_last
    );

    modport slave (
        output fifo_dout,
        output fifo_empty,
        output m_ready,
        input  fifo_read,
        input  m_data,
        input  m_valid,
        input  m_last
    );
endinterface

// File: rtl/fifo_width_down.sv
// Width down-converter: pops IWIDTH-bit words from an FWFT FIFO and emits them
// as RATIO consecutive OWIDTH-bit slices on a valid/ready stream.
module fifo_width_down #(
    parameter int unsigned IWIDTH    = 32,
    parameter int unsigned OWIDTH    = 8,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    fifo_width_down_if.master  bus,
    output logic [15:0]        word_cnt
);

    localparam int unsigned RATIO = IWIDTH / OWIDTH;
    localparam int unsigned IDXW  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(RATIO - 1);

    if ((IWIDTH % OWIDTH) != 0 || RATIO < 2) begin : g_bad_params
        $error("fifo_width_down: IWIDTH must be an integer multiple (>=2) of OWIDTH");
    end

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IWIDTH-1:0] word;
    logic [IDXW-1:0]   idx;
    logic [15:0]       word_cnt_q;
    logic              load;
    logic              advance;
    logic              done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A final-slice handshake may reload in the same cycle, so SEND never
    // leaves a bubble while the FIFO has data.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        advance    = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!bus.fifo_empty) begin
                    load       = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (bus.m_ready) begin
                    if (idx == LAST_IDX) begin
                        done = 1'b1;
                        if (!bus.fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Gated by rst_n so no pop can be requested while reset is held.
    assign bus.fifo_read = load & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word       <= '0;
            idx        <= '0;
            word_cnt_q <= '0;
        end else begin
            if (load) begin
                word <= bus.fifo_dout;
                idx  <= '0;
            end else if (advance) begin
                idx <= idx + 1'b1;
                if (MSB_FIRST) begin
                    word <= word << OWIDTH;
                end else begin
                    word <= word >> OWIDTH;
                end
            end
            if (done) begin
                word_cnt_q <= word_cnt_q + 16'd1;
            end
        end
    end

    // The word shifts toward a fixed output window, so the slice is a constant select.
    assign bus.m_data  = MSB_FIRST ? word[IWIDTH-1 -: OWIDTH] : word[OWIDTH-1:0];
    assign bus.m_valid = (state == SEND);
    assign bus.m_last  = (state == SEND) && (idx == LAST_IDX);
    assign word_cnt    = word_cnt_q;

endmodule

// File: tb/tb_fifo_width_down.sv
// Scoreboard bench for fifo_width_down: LSB-first and MSB-first instances fed
// identical words, expected slices computed arithmetically from each word.
module tb_fifo_width_down;

    localparam int IW    = 32;
    localparam int OW    = 8;
    localparam int RATIO = IW / OW;

    typedef struct packed {
        logic [OW-1:0] d;
        logic          last;
    } slice_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_width_down_if #(.IWIDTH(IW), .OWIDTH(OW)) bus_lsb ();
    fifo_width_down_if #(.IWIDTH(IW), .OWIDTH(OW)) bus_msb ();
    logic [15:0] wc_lsb;
    logic [15:0] wc_msb;

    fifo_width_down #(.IWIDTH(IW), .OWIDTH(OW), .MSB_FIRST(1'b0)) u_lsb (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_lsb.master),
        .word_cnt (wc_lsb)
    );

    fifo_width_down #(.IWIDTH(IW), .OWIDTH(OW), .MSB_FIRST(1'b1)) u_msb (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_msb.master),
        .word_cnt (wc_msb)
    );

    logic [IW-1:0] up_lsb[$];
    logic [IW-1:0] up_msb[$];
    slice_t        exp_lsb[$];
    slice_t        exp_msb[$];
    logic [15:0]   exp_cnt_lsb = 16'd0;
    logic [15:0]   exp_cnt_msb = 16'd0;

    int n_pass  = 0;
    int n_total = 0;

    logic          rd_l, rd_m, obs_v;
    logic [OW-1:0] obs_d;
    logic          hold_v[2];
    logic [OW-1:0] hold_d[2];
    logic          hold_last[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    task automatic refresh();
        bus_lsb.fifo_empty = (up_lsb.size() == 0);
        bus_lsb.fifo_dout  = (up_lsb.size() != 0) ? up_lsb[0] : IW'($urandom);
        bus_msb.fifo_empty = (up_msb.size() == 0);
        bus_msb.fifo_dout  = (up_msb.size() != 0) ? up_msb[0] : IW'($urandom);
    endtask

    task automatic push_word(input logic [IW-1:0] w);
        slice_t s;
        up_lsb.push_back(w);
        up_msb.push_back(w);
        for (int k = 0; k < RATIO; k++) begin
            s.last = (k == RATIO - 1);
            s.d    = OW'(w >> (k * OW));
            exp_lsb.push_back(s);
            s.d    = OW'(w >> ((RATIO - 1 - k) * OW));
            exp_msb.push_back(s);
        end
        refresh();
    endtask

    // One clock: sample at the falling edge, apply pops just after the rising edge.
    task automatic tick();
        @(negedge clk);
        rd_l  = bus_lsb.fifo_read;
        rd_m  = bus_msb.fifo_read;
        obs_v = bus_lsb.m_valid;
        obs_d = bus_lsb.m_data;
        @(posedge clk);
        #1;
        if (rd_l && up_lsb.size() != 0) void'(up_lsb.pop_front());
        if (rd_m && up_msb.size() != 0) void'(up_msb.pop_front());
        refresh();
    endtask

    task automatic observe(input int n, output logic [31:0] rdm, output logic [31:0] vm);
        rdm = '0;
        vm  = '0;
        for (int k = 0; k < n; k++) begin
            tick();
            rdm[k] = rd_l;
            vm[k]  = obs_v;
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        bus_lsb.m_ready = 1'b1;
        bus_msb.m_ready = 1'b1;
        while ((exp_lsb.size() != 0 || exp_msb.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        n_total++;
        if (exp_lsb.size() != 0 || exp_msb.size() != 0)
            $display("FAIL %s_drain_timeout: pending slices %0d/%0d, required 0/0", tag, exp_lsb.size(), exp_msb.size());
        else
            n_pass++;
        tick();
        tick();
    endtask

    task automatic mon_lane(input int l, input logic v, input logic r, input logic [OW-1:0] d,
                            input logic last, input logic [15:0] wc, input logic rd, input logic emp);
        slice_t e;
        logic   have;
        string  p;
        p = (l == 0) ? "lsb" : "msb";
        chk({p, "_word_cnt"}, 32'(wc), 32'((l == 0) ? exp_cnt_lsb : exp_cnt_msb));
        if (rd) chk({p, "_read_while_empty"}, 32'(emp), 32'd0);
        if (hold_v[l]) begin
            chk({p, "_stall_valid"}, 32'(v), 32'd1);
            chk({p, "_stall_data"}, 32'(d), 32'(hold_d[l]));
            chk({p, "_stall_last"}, 32'(last), 32'(hold_last[l]));
        end
        if (!v) chk({p, "_last_without_valid"}, 32'(last), 32'd0);
        if (v && r) begin
            have = (l == 0) ? (exp_lsb.size() != 0) : (exp_msb.size() != 0);
            if (!have) begin
                n_total++;
                $display("FAIL %s_unexpected_slice: got 0x%0h, required no slice (t=%0t)", p, d, $time);
            end else begin
                if (l == 0) e = exp_lsb.pop_front();
                else        e = exp_msb.pop_front();
                chk({p, "_slice_data"}, 32'(d), 32'(e.d));
                chk({p, "_slice_last"}, 32'(last), 32'(e.last));
                if (e.last) begin
                    if (l == 0) exp_cnt_lsb = exp_cnt_lsb + 16'd1;
                    else        exp_cnt_msb = exp_cnt_msb + 16'd1;
                end
            end
        end
        hold_v[l]    = v && !r;
        hold_d[l]    = d;
        hold_last[l] = last;
    endtask

    initial begin
        hold_v[0] = 1'b0;
        hold_v[1] = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_v[0] = 1'b0;
                hold_v[1] = 1'b0;
            end
            mon_lane(0, bus_lsb.m_valid, bus_lsb.m_ready, bus_lsb.m_data, bus_lsb.m_last,
                     wc_lsb, bus_lsb.fifo_read, bus_lsb.fifo_empty);
            mon_lane(1, bus_msb.m_valid, bus_msb.m_ready, bus_msb.m_data, bus_msb.m_last,
                     wc_msb, bus_msb.fifo_read, bus_msb.fifo_empty);
        end
    end

    initial begin
        logic [31:0] rdm, vm;
        bus_lsb.m_ready = 1'b0;
        bus_msb.m_ready = 1'b0;
        refresh();

        // Reset held with a word waiting upstream.
        push_word(32'h4433_2211);
        tick();
        tick();
        chk("rst_fifo_read_lsb", 32'(bus_lsb.fifo_read), 32'd0);
        chk("rst_fifo_read_msb", 32'(bus_msb.fifo_read), 32'd0);
        chk("rst_m_valid", 32'(bus_lsb.m_valid), 32'd0);
        chk("rst_m_last", 32'(bus_lsb.m_last), 32'd0);
        chk("rst_m_data_lsb", 32'(bus_lsb.m_data), 32'd0);
        chk("rst_m_data_msb", 32'(bus_msb.m_data), 32'd0);
        chk("rst_word_cnt", 32'(wc_lsb), 32'd0);

        // Single word: one pop, then four back-to-back slices.
        bus_lsb.m_ready = 1'b1;
        bus_msb.m_ready = 1'b1;
        rst_n = 1'b1;
        observe(6, rdm, vm);
        chk("one_word_read_cycles", rdm, 32'h0000_0001);
        chk("one_word_valid_cycles", vm, 32'h0000_001E);
        drain("one_word");
        chk("one_word_cnt_lsb", 32'(wc_lsb), 32'd1);
        chk("one_word_cnt_msb", 32'(wc_msb), 32'd1);

        // Three queued words stream with no bubble.
        push_word(32'h4433_2211);
        push_word($urandom);
        push_word($urandom);
        observe(14, rdm, vm);
        chk("three_word_read_cycles", rdm, 32'h0000_0111);
        chk("three_word_valid_cycles", vm, 32'h0000_1FFE);
        drain("three_word");
        chk("three_word_cnt", 32'(wc_lsb), 32'd4);

        // Stall on slice index 2 with another word waiting.
        push_word(32'h4433_2211);
        push_word(32'hA5A5_5A5A);
        repeat (3) tick();
        bus_lsb.m_ready = 1'b0;
        bus_msb.m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_data_0x33", 32'(obs_d), 32'h33);
            chk("stall_no_read", 32'(rd_l), 32'd0);
            chk("stall_valid", 32'(obs_v), 32'd1);
        end
        drain("stall");
        chk("stall_word_cnt", 32'(wc_lsb), 32'd6);

        // Reset after two slices of a word; the partial word is dropped.
        push_word($urandom);
        push_word($urandom);
        repeat (3) tick();
        rst_n = 1'b0;
        while (exp_lsb.size() > up_lsb.size() * RATIO) void'(exp_lsb.pop_front());
        while (exp_msb.size() > up_msb.size() * RATIO) void'(exp_msb.pop_front());
        exp_cnt_lsb = 16'd0;
        exp_cnt_msb = 16'd0;
        #1;
        chk("midrst_m_valid", 32'(bus_lsb.m_valid), 32'd0);
        chk("midrst_word_cnt", 32'(wc_lsb), 32'd0);
        chk("midrst_fifo_read", 32'(bus_lsb.fifo_read), 32'd0);
        tick();
        rst_n = 1'b1;
        drain("midrst");
        chk("midrst_word_cnt_after", 32'(wc_msb), 32'd1);

        // Counter wrap from 0xFFFF.
        force u_lsb.word_cnt_q = 16'hFFFF;
        force u_msb.word_cnt_q = 16'hFFFF;
        exp_cnt_lsb = 16'hFFFF;
        exp_cnt_msb = 16'hFFFF;
        tick();
        release u_lsb.word_cnt_q;
        release u_msb.word_cnt_q;
        tick();
        push_word(32'h4433_2211);
        drain("wrap");
        chk("wrap_word_cnt_lsb", 32'(wc_lsb), 32'd0);
        chk("wrap_word_cnt_msb", 32'(wc_msb), 32'd0);

        // Random words and random back-pressure per lane.
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 2) == 0 && up_lsb.size() < 6) push_word($urandom);
            bus_lsb.m_ready = ($urandom_range(0, 3) != 0);
            bus_msb.m_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain("random");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
